// File: rtl/ariane_pkg.sv
// Shared types for the write-back path: exception payload, per-FU result slot,
// and the index-width helper used by the collector and its arbiter.
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [63:0]              data;
    exception_t               ex;
  } wb_slot_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_multi_arbiter.sv
// Combinational round-robin arbiter granting up to M of N requests per cycle,
// scanning from ptr_i upward and compacting winners onto the lowest ports.
module rr_multi_arbiter
  import ariane_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned M     = 2,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]            req_i,
  input  logic [IDX_W-1:0]        ptr_i,
  output logic [N-1:0]            gnt_o,
  output logic [M-1:0][IDX_W-1:0] idx_o,
  output logic [M-1:0]            valid_o,
  output logic [IDX_W-1:0]        ptr_o
);

  // NOTE: every output and loop temporary gets a default before the scan so
  // no path through this block leaves a value unassigned (no latches).
  always_comb begin
    int unsigned cnt;
    int unsigned j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = '0;
    ptr_o   = ptr_i;
    cnt     = 0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (req_i[j] && (cnt < M)) begin
        gnt_o[j]     = 1'b1;
        idx_o[cnt]   = IDX_W'(j);
        valid_o[cnt] = 1'b1;
        ptr_o        = (j + 1 == N) ? '0 : IDX_W'(j + 1);
        cnt          = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/wb_collector.sv
// Buffers one result per functional unit and drains them round-robin onto
// registered scoreboard write-back ports as one-cycle pulses.
module wb_collector
  import ariane_pkg::*;
#(
  parameter int unsigned NR_FU       = 4,
  parameter int unsigned NR_WB_PORTS = 2
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  input  logic [NR_FU-1:0]                            fu_valid_i,
  output logic [NR_FU-1:0]                            fu_ready_o,
  input  logic [NR_FU-1:0][TRANS_ID_BITS-1:0]         fu_trans_id_i,
  input  logic [NR_FU-1:0][63:0]                      fu_data_i,
  input  exception_t [NR_FU-1:0]                      fu_ex_i,
  output logic [NR_WB_PORTS-1:0]                      wt_valid_o,
  output logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   trans_id_o,
  output logic [NR_WB_PORTS-1:0][63:0]                wbdata_o,
  output exception_t [NR_WB_PORTS-1:0]                ex_o
);

  localparam int unsigned IDX_W = idx_w(NR_FU);

  wb_slot_t [NR_FU-1:0]              slot_q;
  wb_slot_t [NR_WB_PORTS-1:0]        out_q;
  logic [IDX_W-1:0]                  rr_ptr_q, rr_ptr_n;
  logic [NR_FU-1:0]                  slot_valid, grant;
  logic [NR_WB_PORTS-1:0][IDX_W-1:0] win_idx;
  logic [NR_WB_PORTS-1:0]            win_valid;

  // Ready depends only on registered slot state and flush, never on fu_valid_i.
  always_comb begin
    slot_valid = '0;
    fu_ready_o = '0;
    for (int unsigned i = 0; i < NR_FU; i++) begin
      slot_valid[i] = slot_q[i].valid;
      fu_ready_o[i] = !flush_i && (!slot_q[i].valid || grant[i]);
    end
  end

  rr_multi_arbiter #(
    .N     (NR_FU),
    .M     (NR_WB_PORTS),
    .IDX_W (IDX_W)
  ) i_arb (
    .req_i   (slot_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (grant),
    .idx_o   (win_idx),
    .valid_o (win_valid),
    .ptr_o   (rr_ptr_n)
  );

  // NOTE: slots are a handful of flops rather than a RAM, so resetting the
  // whole array is cheap and keeps stale payload from ever reaching a port.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q   <= '0;
      out_q    <= '0;
      rr_ptr_q <= '0;
    end else if (flush_i) begin
      slot_q   <= '0;
      out_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let out_q read the pre-edge slot
      // contents even when the same slot is refilled at this edge.
      for (int unsigned i = 0; i < NR_FU; i++) begin
        if (fu_valid_i[i] && fu_ready_o[i]) begin
          slot_q[i] <= '{valid: 1'b1, trans_id: fu_trans_id_i[i],
                         data: fu_data_i[i], ex: fu_ex_i[i]};
        end else if (grant[i]) begin
          slot_q[i] <= '0;
        end
      end
      for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
        out_q[p] <= win_valid[p] ? slot_q[win_idx[p]] : '0;
      end
      rr_ptr_q <= rr_ptr_n;
    end
  end

  always_comb begin
    wt_valid_o = '0;
    trans_id_o = '0;
    wbdata_o   = '0;
    ex_o       = '0;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      wt_valid_o[p] = out_q[p].valid;
      trans_id_o[p] = out_q[p].trans_id;
      wbdata_o[p]   = out_q[p].data;
      ex_o[p]       = out_q[p].ex;
    end
  end

endmodule

// File: tb/tb_wb_collector.sv
// Self-checking bench for wb_collector: directed scenarios with literal
// expectations plus randomized traffic against a slot/queue reference model.
module tb_wb_collector;
  import ariane_pkg::*;

  localparam int unsigned NF = 4;
  localparam int unsigned NP = 2;

  logic                                 clk_i = 1'b0;
  logic                                 rst_i;
  logic                                 flush_i;
  logic [NF-1:0]                        fu_valid;
  logic [NF-1:0]                        fu_ready_o;
  logic [NF-1:0][TRANS_ID_BITS-1:0]     fu_tid;
  logic [NF-1:0][63:0]                  fu_data;
  exception_t [NF-1:0]                  fu_ex;
  logic [NP-1:0]                        wt_valid_o;
  logic [NP-1:0][TRANS_ID_BITS-1:0]     trans_id_o;
  logic [NP-1:0][63:0]                  wbdata_o;
  exception_t [NP-1:0]                  ex_o;

  wb_collector #(.NR_FU(NF), .NR_WB_PORTS(NP)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .fu_valid_i    (fu_valid),
    .fu_ready_o    (fu_ready_o),
    .fu_trans_id_i (fu_tid),
    .fu_data_i     (fu_data),
    .fu_ex_i       (fu_ex),
    .wt_valid_o    (wt_valid_o),
    .trans_id_o    (trans_id_o),
    .wbdata_o      (wbdata_o),
    .ex_o          (ex_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: what each FU has waiting, and where the scan starts.
  bit                       m_v   [NF];
  logic [TRANS_ID_BITS-1:0] m_id  [NF];
  logic [63:0]              m_d   [NF];
  exception_t               m_ex  [NF];
  int                       m_ptr;
  bit                       e_wv  [NP];
  logic [TRANS_ID_BITS-1:0] e_id  [NP];
  logic [63:0]              e_d   [NP];
  exception_t               e_ex  [NP];

  task automatic model_clear();
    for (int i = 0; i < NF; i++) begin
      m_v[i] = 0; m_id[i] = '0; m_d[i] = '0; m_ex[i] = '0;
    end
    for (int p = 0; p < NP; p++) begin
      e_wv[p] = 0; e_id[p] = '0; e_d[p] = '0; e_ex[p] = '0;
    end
    m_ptr = 0;
  endtask

  // One clock cycle: inputs are already driven; check ready, advance model
  // at the edge, then compare the registered outputs on the falling edge.
  task automatic step();
    int  order[$];
    int  win[$];
    bit  g[NF];
    bit  acc[NF];
    bit  rdy;
    #1;
    order = {};
    for (int off = 0; off < NF; off++)
      if (m_v[(m_ptr + off) % NF]) order.push_back((m_ptr + off) % NF);
    win = {};
    for (int k = 0; k < order.size() && k < NP; k++) win.push_back(order[k]);
    for (int i = 0; i < NF; i++) g[i] = 0;
    foreach (win[k]) g[win[k]] = 1;
    for (int i = 0; i < NF; i++) begin
      rdy = !flush_i && (!m_v[i] || g[i]);
      check($sformatf("fu_ready[%0d]", i), fu_ready_o[i], rdy);
      acc[i] = fu_valid[i] && rdy;
    end
    @(posedge clk_i);
    if (flush_i) begin
      model_clear();
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (p < win.size()) begin
          e_wv[p] = 1; e_id[p] = m_id[win[p]]; e_d[p] = m_d[win[p]]; e_ex[p] = m_ex[win[p]];
        end else begin
          e_wv[p] = 0; e_id[p] = '0; e_d[p] = '0; e_ex[p] = '0;
        end
      end
      for (int i = 0; i < NF; i++) begin
        if (acc[i]) begin
          m_v[i] = 1; m_id[i] = fu_tid[i]; m_d[i] = fu_data[i]; m_ex[i] = fu_ex[i];
        end else if (g[i]) begin
          m_v[i] = 0;
        end
      end
      if (win.size() > 0) m_ptr = (win[win.size()-1] + 1) % NF;
    end
    @(negedge clk_i);
    for (int p = 0; p < NP; p++) begin
      check($sformatf("wt_valid[%0d]", p), wt_valid_o[p], e_wv[p]);
      check($sformatf("trans_id[%0d]", p), trans_id_o[p], e_id[p]);
      check($sformatf("wbdata[%0d]", p), wbdata_o[p], e_d[p]);
      check($sformatf("ex[%0d]", p), ex_o[p], e_ex[p]);
    end
  endtask

  task automatic idle_inputs();
    fu_valid = '0; fu_tid = '0; fu_data = '0; fu_ex = '0; flush_i = 1'b0;
  endtask

  task automatic do_flush();
    idle_inputs();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
  endtask

  task automatic rand_inputs(input int flush_pct);
    for (int i = 0; i < NF; i++) begin
      fu_valid[i]    = ($urandom_range(0, 99) < 60);
      fu_tid[i]      = TRANS_ID_BITS'($urandom);
      fu_data[i]     = {$urandom, $urandom};
      fu_ex[i].cause = {$urandom, $urandom};
      fu_ex[i].tval  = {$urandom, $urandom};
      fu_ex[i].valid = $urandom_range(0, 1);
    end
    flush_i = ($urandom_range(0, 99) < flush_pct);
  endtask

  int cnt[NF];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    rst_i = 1'b1;
    model_clear();
    #1;
    check("reset wt_valid", wt_valid_o, 2'b00);
    check("reset wbdata", wbdata_o, '0);
    check("reset trans_id", trans_id_o, '0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("post-reset ready", fu_ready_o, 4'b1111);
    step();

    // Single result from FU1
    do_flush();
    fu_valid[1] = 1'b1; fu_tid[1] = 3'd3; fu_data[1] = 64'hDEAD;
    step();
    idle_inputs();
    step();
    check("single wt_valid", wt_valid_o, 2'b01);
    check("single trans_id0", trans_id_o[0], 3'd3);
    check("single wbdata0", wbdata_o[0], 64'hDEAD);
    step();
    check("single after pulse", wt_valid_o, 2'b00);

    // All four FUs at once
    do_flush();
    fu_valid = 4'b1111;
    for (int i = 0; i < NF; i++) begin
      fu_tid[i] = TRANS_ID_BITS'(i); fu_data[i] = 64'(100 + i);
    end
    step();
    idle_inputs();
    #1;
    check("all ready cycle1", fu_ready_o, 4'b0011);
    step();
    check("all c2 valid", wt_valid_o, 2'b11);
    check("all c2 id0", trans_id_o[0], 3'd0);
    check("all c2 id1", trans_id_o[1], 3'd1);
    step();
    check("all c3 id0", trans_id_o[0], 3'd2);
    check("all c3 id1", trans_id_o[1], 3'd3);
    check("model ptr after all", m_ptr, 0);
    step();
    check("all c4 idle", wt_valid_o, 2'b00);

    // Fairness: FUs 0..2 valid every cycle
    do_flush();
    fu_valid = 4'b0111;
    for (int i = 0; i < NF; i++) begin
      fu_tid[i] = TRANS_ID_BITS'(i); fu_data[i] = 64'(i);
      cnt[i] = 0;
    end
    step();
    for (int c = 0; c < 6; c++) begin
      step();
      for (int p = 0; p < NP; p++) if (wt_valid_o[p]) cnt[trans_id_o[p]]++;
      if (c == 0) begin
        check("fair c1 ids", {trans_id_o[0], trans_id_o[1]}, {3'd0, 3'd1});
      end else if (c == 1) begin
        check("fair c2 ids", {trans_id_o[0], trans_id_o[1]}, {3'd2, 3'd0});
      end else if (c == 2) begin
        check("fair c3 ids", {trans_id_o[0], trans_id_o[1]}, {3'd1, 3'd2});
      end
    end
    for (int i = 0; i < 3; i++) check($sformatf("fair count fu%0d", i), cnt[i], 4);

    // Flush with all slots full; the pre-flush and flush-cycle IDs must vanish
    do_flush();
    fu_valid = 4'b1111;
    for (int i = 0; i < NF; i++) fu_tid[i] = TRANS_ID_BITS'(i);
    step();
    for (int i = 0; i < NF; i++) fu_tid[i] = TRANS_ID_BITS'(4 + i);
    flush_i = 1'b1;
    #1;
    check("flush ready", fu_ready_o, 4'b0000);
    step();
    check("flush wt_valid", wt_valid_o, 2'b00);
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      step();
      check("post-flush wt_valid", wt_valid_o, 2'b00);
    end

    // Exception passthrough from FU3
    do_flush();
    fu_valid[3] = 1'b1; fu_tid[3] = 3'd6; fu_data[3] = 64'h1234;
    fu_ex[3].valid = 1'b1; fu_ex[3].cause = 64'd5; fu_ex[3].tval = 64'h80;
    step();
    idle_inputs();
    step();
    check("exc wt_valid", wt_valid_o, 2'b01);
    check("exc ex0", ex_o[0], {64'd5, 64'h80, 1'b1});
    check("exc trans_id0", trans_id_o[0], 3'd6);
    check("exc wbdata0", wbdata_o[0], 64'h1234);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rand_inputs(3);
      step();
    end

    // Reset mid-traffic: outputs drop without waiting for a clock edge
    for (int c = 0; c < 4; c++) begin
      rand_inputs(0);
      fu_valid = 4'b1111;
      step();
    end
    rst_i = 1'b1;
    #1;
    check("mid reset wt_valid", wt_valid_o, 2'b00);
    check("mid reset wbdata", wbdata_o, '0);
    model_clear();
    @(negedge clk_i);
    idle_inputs();
    rst_i = 1'b0;
    #1;
    check("mid reset ready", fu_ready_o, 4'b1111);
    for (int c = 0; c < 3; c++) begin
      step();
      check("mid reset quiet", wt_valid_o, 2'b00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_collector.md
# wb_collector

Write-back collector between the functional units and the scoreboard write-back ports. It buffers one result per functional unit and arbitrates round-robin onto `NR_WB_PORTS` registered write-back ports. It drives the scoreboard's `trans_id`/`wbdata`/`ex`/`wt_valid` inputs with one-cycle pulses. FUs see a valid/ready handshake and are back-pressured only when their own slot is still occupied.

## Interface
- `NR_FU`, default 4, number of functional-unit result inputs; ≥ `NR_WB_PORTS`.
- `NR_WB_PORTS`, default 2, number of write-back ports toward the scoreboard; ≥ 1.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high; clears all state.
- `flush_i`  in  1  discard all buffered and in-flight results.
- `fu_valid_i`  in  `[NR_FU]`  FU i presents a result.
- `fu_ready_o`  out  `[NR_FU]`  slot i can accept this cycle.
- `fu_trans_id_i`  in  `[NR_FU][TRANS_ID_BITS]`  scoreboard transaction ID of the result.
- `fu_data_i`  in  `[NR_FU][64]`  result data.
- `fu_ex_i`  in  `exception_t [NR_FU]`  exception and fflags payload.
- `wt_valid_o`  out  `[NR_WB_PORTS]`  write-back valid, one-cycle pulse per result.
- `trans_id_o`  out  `[NR_WB_PORTS][TRANS_ID_BITS]`  transaction ID.
- `wbdata_o`  out  `[NR_WB_PORTS][64]`  write-back data.
- `ex_o`  out  `exception_t [NR_WB_PORTS]`  exception payload, forwarded unmodified.

## Operation
- **Slots.** One slot per FU, holding `{valid, trans_id, data, ex}`.
- **Accept.**
  - Slot i loads on `fu_valid_i[i] && fu_ready_o[i]`.
  - `fu_ready_o[i] = !flush_i && (!slot_valid_q[i] || grant[i])`. This is a function of registered state only; there is no combinational path from `fu_valid_i` to `fu_ready_o`.
- **Arbitration.**
  - Combinational over `slot_valid_q`.
  - Scan indices `rr_ptr_q`, `rr_ptr_q+1`, … modulo `NR_FU`. Grant the first `NR_WB_PORTS` occupied slots.
  - The k-th winner in scan order goes to port k, so winners are compacted onto the lowest port indices.
- **Round-robin pointer.**
  - If any slot is granted: `rr_ptr_n` = (index of last granted slot + 1) mod `NR_FU`.
  - Otherwise `rr_ptr_q` is held.
- **Drain.**
  - At the edge, granted slots clear unless they are refilled in the same cycle. Grant and refill of the same slot in one cycle is legal and required.
  - The output registers load the winners.
  - Ports with no winner load `wt_valid=0`.
- **Output hygiene.**
  - `trans_id_o`, `wbdata_o` and `ex_o` are all-zero whenever the corresponding `wt_valid_o` is 0.
  - Each accepted result appears on exactly one port, for exactly one cycle.
- **No downstream back-pressure.** The scoreboard always accepts.
- **Flush.**
  - `flush_i` high in cycle N forces `fu_ready_o=0` in cycle N.
  - At edge N: all slots clear, all output valids clear, `rr_ptr` resets to 0.
  - Any result presented in cycle N is dropped.
- **No ID checking.** The block does not check `trans_id` uniqueness; the FUs guarantee it.

## Timing
- **Reset values.**
  - `wt_valid_o=0`, all payload outputs 0.
  - Slots empty, `rr_ptr=0`.
  - `fu_ready_o` = all ones once `flush_i` is low.
- **Latency.** Result accepted at edge E, uncontended: granted in the cycle after E, `wt_valid_o` high in the cycle after edge E+1. That is 2 cycles from the `fu_valid_i` cycle to the `wt_valid_o` cycle; this is the minimum.
- **Throughput.** Each FU can sustain one result per cycle if it wins every cycle. Aggregate throughput is `NR_WB_PORTS` results per cycle.
- **Starvation bound.** An occupied slot is granted within `ceil(NR_FU/NR_WB_PORTS)` cycles.
- **Reset mid-operation.** All pending results are lost; outputs return to reset values asynchronously.
- **Flush and reset together.** Reset dominates.

## Structure
- Add `wb_slot_t` (`valid`, `trans_id`, `data`, `ex`) to `ariane_pkg` next to `exception_t`. It is reused by the FU wrappers.
- One sub-module, `rr_multi_arbiter`: combinational N-request, M-grant round-robin arbiter.
  - Inputs: request vector, pointer.
  - Outputs: grant vector, per-port winner index, per-port valid, next pointer.
- `wb_collector` holds the slots, output registers and pointer register.

## Test plan
1. **Reset.** Assert `rst_i` mid-traffic → `wt_valid_o=00` immediately. After release: `fu_ready_o=1111`, and no output until new input arrives.
2. **Single result.** FU1 presents `trans_id=3`, `data=0xDEAD`, cycle 0 → cycle 2: `wt_valid_o=01`, `trans_id_o[0]=3`, `wbdata_o[0]=0xDEAD`. Cycle 3: `wt_valid_o=00`.
3. **All FUs at once.** All four FUs valid in cycle 0 with `trans_id` 0..3, `rr_ptr=0`.
   - Cycle 1: `fu_ready_o=0011`.
   - Cycle 2: ports carry IDs 0,1.
   - Cycle 3: ports carry IDs 2,3.
   - Afterwards `rr_ptr=0`.
4. **Fairness.** FUs 0,1,2 valid every cycle → grant sets rotate {0,1}, {2,0}, {1,2}, repeating. Every FU gets exactly 2 grants per 3 cycles.
5. **Flush.** All slots full, `flush_i` pulsed for one cycle → `fu_ready_o=0000` that cycle. From the next cycle on, `wt_valid_o=00`; no pre-flush ID ever appears.
6. **Exception passthrough.** FU3 presents `ex.valid=1`, `cause=5`, `tval=0x80` → on its port: `ex_o` identical, `wbdata_o` and `trans_id_o` passed through.
